// File: rtl/hazard_control_unit.sv
// Pipeline hazard sequencer: load-use bubbles, HI/LO waits on the multiply/divide
// unit, taken-branch squashes, and a saturating stall-cycle counter.
module hazard_control_unit #(
    parameter int unsigned LOAD_STALL_CYCLES = 2,
    parameter int unsigned MDU_LATENCY       = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        id_uses_hilo,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_read,
    input  logic        ex_mdu_start,
    input  logic        ex_branch_taken,
    output logic        pc_stall,
    output logic        if_id_stall,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        mdu_busy,
    output logic [31:0] stall_cycles
);

    localparam int unsigned LCW = 4;
    localparam int unsigned MCW = 6;
    localparam int unsigned SCW = 32;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MDU_WAIT   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [LCW-1:0]   load_cnt_q, load_cnt_d;
    logic [MCW-1:0]   mdu_cnt_q, mdu_cnt_d;
    logic [SCW-1:0]   stall_cycles_q, stall_cycles_d;
    logic             lhaz, mhaz;
    logic             stall_c, flush_c;

    assign mdu_busy     = (mdu_cnt_q != '0);
    assign stall_cycles = stall_cycles_q;

    assign lhaz = ex_mem_read && (ex_rd != 5'd0) &&
                  ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));
    assign mhaz = id_uses_hilo && mdu_busy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= RUN;
            load_cnt_q     <= '0;
            mdu_cnt_q      <= '0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            load_cnt_q     <= load_cnt_d;
            mdu_cnt_q      <= mdu_cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    // MDU result countdown; a new start restarts it, branches never touch it.
    always_comb begin
        mdu_cnt_d = mdu_cnt_q;
        if (ex_mdu_start) begin
            mdu_cnt_d = MCW'(MDU_LATENCY);
        end else if (mdu_cnt_q != '0) begin
            mdu_cnt_d = mdu_cnt_q - MCW'(1);
        end
    end

    // Next state and Mealy controls; a taken branch overrides any pending stall.
    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        stall_c    = 1'b0;
        flush_c    = 1'b0;
        if (ex_branch_taken) begin
            flush_c    = 1'b1;
            state_d    = RUN;
            load_cnt_d = '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (lhaz) begin
                        stall_c = 1'b1;
                        if (LOAD_STALL_CYCLES > 1) begin
                            state_d    = LOAD_STALL;
                            load_cnt_d = LCW'(LOAD_STALL_CYCLES - 1);
                        end
                    end else if (mhaz) begin
                        stall_c = 1'b1;
                        state_d = MDU_WAIT;
                    end
                end
                LOAD_STALL: begin
                    stall_c = 1'b1;
                    if (load_cnt_q <= LCW'(1)) begin
                        load_cnt_d = '0;
                        state_d    = RUN;
                    end else begin
                        load_cnt_d = load_cnt_q - LCW'(1);
                    end
                end
                MDU_WAIT: begin
                    if (mhaz) begin
                        stall_c = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d    = RUN;
                    load_cnt_d = '0;
                end
            endcase
        end
    end

    // Controls are forced low for as long as reset is held.
    always_comb begin
        pc_stall    = reset & stall_c;
        if_id_stall = reset & stall_c;
        if_id_flush = reset & flush_c;
        id_ex_flush = reset & (stall_c | flush_c);
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (pc_stall && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + SCW'(1);
        end
    end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench for hazard_control_unit: directed per-cycle vectors push their
// expected controls into a queue that an independent monitor drains and checks.
module tb_hazard_control_unit;

    localparam logic [3:0] NON = 4'b0000;
    localparam logic [3:0] STL = 4'b1101;
    localparam logic [3:0] FLS = 4'b0011;

    typedef struct packed {
        logic [15:0] idx;
        logic [3:0]  ctl;
        logic        busy;
        logic [31:0] cnt;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [4:0]  id_rs, id_rt, ex_rd;
    logic        id_uses_rs, id_uses_rt, id_uses_hilo;
    logic        ex_mem_read, ex_mdu_start, ex_branch_taken;
    logic        pc_stall, if_id_stall, if_id_flush, id_ex_flush, mdu_busy;
    logic [31:0] stall_cycles;

    exp_t        q[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    int          n_cyc  = 0;
    logic [31:0] sw_cnt = 32'd0;

    hazard_control_unit #(.LOAD_STALL_CYCLES(2), .MDU_LATENCY(8)) dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_uses_hilo(id_uses_hilo),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_mdu_start(ex_mdu_start),
        .ex_branch_taken(ex_branch_taken),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush), .mdu_busy(mdu_busy), .stall_cycles(stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock of stimulus driven at the falling edge, plus its expected response.
    task automatic cyc(input logic rst, input logic [4:0] rs, input logic urs,
                       input logic [4:0] rt, input logic urt, input logic uhl,
                       input logic [4:0] rd, input logic mr, input logic ms, input logic br,
                       input logic [3:0] ctl, input logic busy);
        exp_t e;
        @(negedge clk);
        reset = rst; id_rs = rs; id_uses_rs = urs; id_rt = rt; id_uses_rt = urt;
        id_uses_hilo = uhl; ex_rd = rd; ex_mem_read = mr; ex_mdu_start = ms;
        ex_branch_taken = br;
        if (!rst) sw_cnt = 32'd0;
        e.idx  = 16'(n_cyc);
        e.ctl  = ctl;
        e.busy = busy;
        e.cnt  = sw_cnt;
        q.push_back(e);
        if (rst && ctl[3] && (sw_cnt != 32'hFFFF_FFFF)) sw_cnt = sw_cnt + 32'd1;
        n_cyc++;
    endtask

    task automatic idle(input logic busy);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, NON, busy);
    endtask

    task automatic hilo(input logic [3:0] ctl, input logic busy);
        cyc(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, ctl, busy);
    endtask

    task automatic mdu_start();
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, NON, 0);
    endtask

    // Monitor: samples mid-cycle, well clear of the rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() != 0) begin
                e = q.pop_front();
                n_chk++;
                if ({pc_stall, if_id_stall, if_id_flush, id_ex_flush} !== e.ctl) begin
                    n_fail++;
                    $display("FAIL ctl cyc=%0d got=%b exp=%b", e.idx,
                             {pc_stall, if_id_stall, if_id_flush, id_ex_flush}, e.ctl);
                end
                n_chk++;
                if (mdu_busy !== e.busy) begin
                    n_fail++;
                    $display("FAIL mdu_busy cyc=%0d got=%b exp=%b", e.idx, mdu_busy, e.busy);
                end
                n_chk++;
                if (stall_cycles !== e.cnt) begin
                    n_fail++;
                    $display("FAIL stall_cycles cyc=%0d got=%h exp=%h", e.idx, stall_cycles, e.cnt);
                end
                n_chk++;
                if (if_id_flush && if_id_stall) begin
                    n_fail++;
                    $display("FAIL flush_stall_excl cyc=%0d got=11 exp=not both", e.idx);
                end
            end
        end
    end

    initial begin
        int waited;
        reset = 1'b0; id_rs = '0; id_rt = '0; ex_rd = '0;
        id_uses_rs = 0; id_uses_rt = 0; id_uses_hilo = 0;
        ex_mem_read = 0; ex_mdu_start = 0; ex_branch_taken = 0;

        // Reset held with a live load hazard and MDU start: everything stays quiet.
        repeat (3) cyc(0, 5, 1, 0, 0, 0, 5, 1, 1, 0, NON, 0);

        // Load-use on rs right after release: exactly two bubbles.
        cyc(1, 5, 1, 0, 0, 0, 5, 1, 0, 0, STL, 0);
        cyc(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, STL, 0);
        cyc(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, NON, 0);
        idle(0);

        // No hazard: ex_rd = 0, rs not read, register mismatch.
        cyc(1, 0, 1, 0, 0, 0, 0, 1, 0, 0, NON, 0);
        cyc(1, 5, 0, 0, 0, 0, 5, 1, 0, 0, NON, 0);
        cyc(1, 4, 1, 6, 1, 0, 7, 1, 0, 0, NON, 0);

        // Load-use on rt.
        cyc(1, 0, 0, 7, 1, 0, 7, 1, 0, 0, STL, 0);
        cyc(1, 0, 0, 7, 1, 0, 0, 0, 0, 0, STL, 0);
        cyc(1, 0, 0, 7, 1, 0, 0, 0, 0, 0, NON, 0);

        // MFHI right behind MULT: stalled while the counter runs 8..1.
        mdu_start();
        repeat (8) hilo(STL, 1);
        hilo(NON, 0);
        idle(0);

        // Restart while busy extends the wait.
        mdu_start();
        repeat (3) idle(1);
        cyc(1, 0, 0, 0, 0, 1, 0, 0, 1, 0, STL, 1);
        repeat (8) hilo(STL, 1);
        hilo(NON, 0);

        // Branch squashes an MDU wait without touching the counter; non-HI/LO instr leaves.
        mdu_start();
        hilo(STL, 1);
        cyc(1, 0, 0, 0, 0, 1, 0, 0, 0, 1, FLS, 1);
        idle(1);
        hilo(STL, 1);
        idle(1);
        repeat (3) idle(1);
        idle(0);

        // Branch on the second load-stall cycle, then back to RUN.
        cyc(1, 5, 1, 0, 0, 0, 5, 1, 0, 0, STL, 0);
        cyc(1, 5, 1, 0, 0, 0, 0, 0, 0, 1, FLS, 0);
        cyc(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, NON, 0);

        // Branch coinciding with a load hazard in RUN discards the stall.
        cyc(1, 5, 1, 0, 0, 0, 5, 1, 0, 1, FLS, 0);
        cyc(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, NON, 0);

        // Load and MDU hazards together with mdu_cnt = 5: load first, then HI/LO wait.
        mdu_start();
        repeat (3) idle(1);
        cyc(1, 3, 1, 0, 0, 1, 3, 1, 0, 0, STL, 1);
        repeat (4) cyc(1, 3, 1, 0, 0, 1, 0, 0, 0, 0, STL, 1);
        cyc(1, 3, 1, 0, 0, 1, 0, 0, 0, 0, NON, 0);
        idle(0);

        // Saturation: preload the counter near the top, then stall.
        #3;
        force dut.stall_cycles_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cycles_q;
        sw_cnt = 32'hFFFF_FFFE;
        mdu_start();
        repeat (8) hilo(STL, 1);
        hilo(NON, 0);
        idle(0);

        waited = 0;
        while ((q.size() != 0) && (waited < 20)) begin
            @(posedge clk);
            waited++;
        end
        if (q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain got=%0d pending exp=0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
